// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle ARM datapath (shared memory, IR, ALU reused for PC+4).
// Build option CTRL_MEMWAIT_EN: when defined, memory states stall on mem_ready; otherwise each lasts one cycle.
module multicycle_ctrl #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        IRWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic [1:0]  ResultSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [3:0]  ALUControl,
   output logic        BranchLink,
   output logic        Rs_in_shifter,
   output logic        carry_flag,
   output logic        illegal,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0010;

   state_t      cur_state;
   state_t      next_state;
   logic [3:0]  nzcv;
   logic [3:0]  exec_flags;
   logic        cond_pass;
   logic        mem_ok;
   logic        pc_write;
   logic        ir_write;
   logic        mem_write;
   logic        reg_write;
   logic        branch_link;
   logic        illegal_dec;

   logic [3:0]  cond;
   logic [1:0]  op;
   logic        imm_form;
   logic [3:0]  opcode;
   logic        set_flags;
   logic        rd_is_pc;
   logic        is_test_op;
   logic        flag_n;
   logic        flag_z;
   logic        flag_c;
   logic        flag_v;

   assign cond       = Instr[31:28];
   assign op         = Instr[27:26];
   assign imm_form   = Instr[25];
   assign opcode     = Instr[24:21];
   assign set_flags  = Instr[20];
   assign rd_is_pc   = (Instr[15:12] == 4'hF);
   assign is_test_op = (opcode[3:2] == 2'b10);

   assign {flag_n, flag_z, flag_c, flag_v} = nzcv;

`ifdef CTRL_MEMWAIT_EN
   assign mem_ok = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_ok = 1'b1;
`endif

   logic unused_instr_bits;
   assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

   // Condition codes are judged only against the committed NZCV register.
   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         4'b0000: cond_pass = flag_z;
         4'b0001: cond_pass = ~flag_z;
         4'b0010: cond_pass = flag_c;
         4'b0011: cond_pass = ~flag_c;
         4'b0100: cond_pass = flag_n;
         4'b0101: cond_pass = ~flag_n;
         4'b0110: cond_pass = flag_v;
         4'b0111: cond_pass = ~flag_v;
         4'b1000: cond_pass = flag_c & ~flag_z;
         4'b1001: cond_pass = ~flag_c | flag_z;
         4'b1010: cond_pass = (flag_n == flag_v);
         4'b1011: cond_pass = (flag_n != flag_v);
         4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_pass = flag_z | (flag_n != flag_v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   always_comb begin
      next_state    = cur_state;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      branch_link   = 1'b0;
      illegal_dec   = 1'b0;
      AdrSrc        = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ResultSrc     = 2'b00;
      RegSrc        = 2'b00;
      Rs_in_shifter = 1'b0;
      ALUControl    = ALU_ADD;
      case (cur_state)
         FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (mem_ok) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               next_state = DECODE;
            end
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (!cond_pass) begin
               next_state = FETCH;
            end else begin
               case (op)
                  2'b00:   next_state = imm_form ? EXECUTEI : EXECUTER;
                  2'b01:   next_state = MEMADR;
                  2'b10:   next_state = BRANCH;
                  default: begin
                     next_state  = FETCH;
                     illegal_dec = 1'b1;
                  end
               endcase
            end
         end
         EXECUTER, EXECUTEI: begin
            ALUControl = opcode;
            next_state = ALUWB;
         end
         ALUWB: begin
            reg_write  = ~is_test_op;
            pc_write   = ~is_test_op & rd_is_pc;
            next_state = FETCH;
         end
         MEMADR: begin
            ALUSrcB       = 2'b01;
            ALUControl    = Instr[23] ? ALU_ADD : ALU_SUB;
            Rs_in_shifter = imm_form;
            next_state    = set_flags ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ok) next_state = MEMWB;
         end
         MEMWB: begin
            ResultSrc  = 2'b01;
            reg_write  = 1'b1;
            pc_write   = rd_is_pc;
            next_state = FETCH;
         end
         MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
            RegSrc[1] = 1'b1;
            if (mem_ok) next_state = FETCH;
         end
         BRANCH: begin
            RegSrc[0]   = 1'b1;
            ALUSrcB     = 2'b01;
            ResultSrc   = 2'b10;
            pc_write    = 1'b1;
            branch_link = Instr[24];
            reg_write   = Instr[24];
            next_state  = FETCH;
         end
         default: next_state = FETCH;
      endcase
   end

   // Flags are sampled in EXECUTE and only committed in ALUWB, so a failed S-bit test never leaks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state  <= state_t'(RESET_STATE);
         nzcv       <= 4'b0000;
         exec_flags <= 4'b0000;
      end else begin
         cur_state <= next_state;
         if (cur_state == EXECUTER || cur_state == EXECUTEI)
            exec_flags <= ALUFlags;
         if (cur_state == ALUWB && set_flags)
            nzcv <= exec_flags;
      end
   end

   assign PCWrite    = pc_write & ~reset;
   assign IRWrite    = ir_write & ~reset;
   assign MemWrite   = mem_write & ~reset;
   assign RegWrite   = reg_write & ~reset;
   assign BranchLink = branch_link & ~reset;
   assign illegal    = illegal_dec & ~reset;
   assign ImmSrc     = op;
   assign carry_flag = flag_c;
   assign state      = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each instruction is planned into per-cycle
// stimulus/expected records, then replayed against the DUT one clock at a time.
module tb_multicycle_ctrl;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] ADD        = 4'b0100;
   localparam logic [3:0] SUB        = 4'b0010;
   localparam logic [25:0] BASE_MASK = 26'h38FFC00;

   logic        clk;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        mem_ready;
   logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
   logic [1:0]  ResultSrc;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB, ImmSrc, RegSrc;
   logic [3:0]  ALUControl;
   logic        BranchLink, Rs_in_shifter, carry_flag, illegal;
   logic [3:0]  state;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .BranchLink(BranchLink),
      .Rs_in_shifter(Rs_in_shifter), .carry_flag(carry_flag), .illegal(illegal), .state(state)
   );

   typedef struct {
      logic [31:0] instr;
      logic        rdy;
      logic [3:0]  flags;
      logic [25:0] exp;
      logic [25:0] mask;
   } cyc_t;

   cyc_t       sb[$];
   logic [3:0] m_nzcv;
   int         num_vectors;
   int         num_miscompares;

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      num_vectors++;
      if (obs !== exp) begin
         num_miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [25:0] mkVec(input logic [1:0] imm, input logic cy, input logic [1:0] rsel,
                                         input logic rs, input logic [3:0] st, input logic [5:0] strb,
                                         input logic adr, input logic srca, input logic [1:0] srcb,
                                         input logic [1:0] rsrc, input logic [3:0] aluc);
      return {imm, cy, rsel, rs, st, strb, adr, srca, srcb, rsrc, aluc};
   endfunction

   function automatic logic [25:0] obsVec();
      return {ImmSrc, carry_flag, RegSrc, Rs_in_shifter, state, PCWrite, IRWrite, MemWrite,
              RegWrite, BranchLink, illegal, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl};
   endfunction

   // Only the mux selects each state actually defines are compared.
   function automatic logic [25:0] stateMask(input logic [3:0] st);
      case (st)
         S_FETCH:          return BASE_MASK | 26'h00003FF;
         S_DECODE:         return BASE_MASK | 26'h00001F0;
         S_EXECR, S_EXECI: return BASE_MASK | 26'h00001CF;
         S_ALUWB, S_MEMWB: return BASE_MASK | 26'h0000030;
         S_MEMADR:         return BASE_MASK | 26'h01001CF;
         S_MEMREAD:        return BASE_MASK | 26'h0000200;
         S_MEMWRITE:       return BASE_MASK | 26'h0400200;
         S_BRANCH:         return BASE_MASK | 26'h02001FF;
         default:          return BASE_MASK;
      endcase
   endfunction

   function automatic string stateName(input logic [3:0] st);
      case (st)
         S_FETCH:    return "fetch";
         S_DECODE:   return "decode";
         S_MEMADR:   return "memadr";
         S_MEMREAD:  return "memread";
         S_MEMWB:    return "memwb";
         S_MEMWRITE: return "memwrite";
         S_EXECR:    return "executer";
         S_EXECI:    return "executei";
         S_ALUWB:    return "aluwb";
         S_BRANCH:   return "branch";
         default:    return "unknown";
      endcase
   endfunction

   function automatic logic condPass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      {n, z, cy, v} = f;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cy;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cy && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return base ^ c[0];
   endfunction

   task automatic push(input logic [31:0] ins, input logic rdy, input logic [3:0] fl, input logic [3:0] st,
                       input logic pcw, input logic irw, input logic memw, input logic regw,
                       input logic bl, input logic ill, input logic [1:0] rsel, input logic rs,
                       input logic adr, input logic srca, input logic [1:0] srcb,
                       input logic [1:0] rsrc, input logic [3:0] aluc);
      cyc_t c;
      c.instr = ins;
      c.rdy   = rdy;
      c.flags = fl;
      c.exp   = mkVec(ins[27:26], m_nzcv[1], rsel, rs, st, {pcw, irw, memw, regw, bl, ill},
                      adr, srca, srcb, rsrc, aluc);
      c.mask  = stateMask(st);
      sb.push_back(c);
   endtask

   task automatic pushMem(input logic [31:0] ins, input logic [3:0] fl, input logic [3:0] st, input int waits);
      logic wr;
      wr = (st == S_MEMWRITE);
`ifdef CTRL_MEMWAIT_EN
      for (int i = 0; i < waits; i++)
         push(ins, 1'b0, fl, st, 0, 0, wr, 0, 0, 0, {wr, 1'b0}, 0, 1, 0, 2'b00, 2'b00, ADD);
      push(ins, 1'b1, fl, st, 0, 0, wr, 0, 0, 0, {wr, 1'b0}, 0, 1, 0, 2'b00, 2'b00, ADD);
`else
      push(ins, waits == 0, fl, st, 0, 0, wr, 0, 0, 0, {wr, 1'b0}, 0, 1, 0, 2'b00, 2'b00, ADD);
`endif
   endtask

   // Reference sequence for one instruction; ALUFlags carries the inverted value outside EXECUTE.
   task automatic planInstr(input logic [31:0] ins, input logic [3:0] fl, input int fwait, input int mwait);
      logic [3:0] nf;
      logic       pass, regw, rd15;
      nf   = ~fl;
      rd15 = (ins[15:12] == 4'hF);
`ifdef CTRL_MEMWAIT_EN
      for (int i = 0; i < fwait; i++)
         push(ins, 1'b0, nf, S_FETCH, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b10, 2'b10, ADD);
      push(ins, 1'b1, nf, S_FETCH, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b10, 2'b10, ADD);
`else
      push(ins, fwait == 0, nf, S_FETCH, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b10, 2'b10, ADD);
`endif
      pass = condPass(ins[31:28], m_nzcv);
      push(ins, 1'b1, nf, S_DECODE, 0, 0, 0, 0, 0, pass && ins[27:26] == 2'b11,
           2'b00, 0, 0, 1, 2'b10, 2'b10, ADD);
      if (!pass || ins[27:26] == 2'b11) return;
      case (ins[27:26])
         2'b00: begin
            push(ins, 1'b1, fl, ins[25] ? S_EXECI : S_EXECR, 0, 0, 0, 0, 0, 0,
                 2'b00, 0, 0, 0, 2'b00, 2'b00, ins[24:21]);
            regw = (ins[24:23] != 2'b10);
            push(ins, 1'b1, nf, S_ALUWB, regw && rd15, 0, 0, regw, 0, 0,
                 2'b00, 0, 0, 0, 2'b00, 2'b00, ADD);
            if (ins[20]) m_nzcv = fl;
         end
         2'b01: begin
            push(ins, 1'b1, nf, S_MEMADR, 0, 0, 0, 0, 0, 0, 2'b00, ins[25], 0, 0, 2'b01, 2'b00,
                 ins[23] ? ADD : SUB);
            if (ins[20]) begin
               pushMem(ins, nf, S_MEMREAD, mwait);
               push(ins, 1'b1, nf, S_MEMWB, rd15, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b01, ADD);
            end else begin
               pushMem(ins, nf, S_MEMWRITE, mwait);
            end
         end
         default: begin
            push(ins, 1'b1, nf, S_BRANCH, 1, 0, 0, ins[24], ins[24], 0, 2'b01, 0, 0, 0, 2'b01,
                 2'b10, ADD);
         end
      endcase
   endtask

   // Entered just after a rising edge; drives a record, samples at the falling edge.
   task automatic applyStimulus(input int n);
      cyc_t c;
      for (int k = 0; k < n && sb.size() > 0; k++) begin
         c = sb.pop_front();
         Instr     = c.instr;
         mem_ready = c.rdy;
         ALUFlags  = c.flags;
         @(negedge clk);
         checkOutput(stateName(c.exp[19:16]), {6'b0, obsVec() & c.mask}, {6'b0, c.exp & c.mask});
         @(posedge clk);
         #1;
      end
   endtask

   task automatic runInstr(input logic [31:0] ins, input logic [3:0] fl, input int fwait, input int mwait);
      planInstr(ins, fl, fwait, mwait);
      applyStimulus(1000);
   endtask

   initial begin
      logic [31:0] rins;
      clk             = 1'b0;
      reset           = 1'b1;
      Instr           = 32'h0;
      ALUFlags        = 4'hF;
      mem_ready       = 1'b1;
      m_nzcv          = 4'h0;
      num_vectors     = 0;
      num_miscompares = 0;

      @(posedge clk);
      #1;
      checkOutput("reset_state", {6'b0, obsVec() & BASE_MASK},
                  {6'b0, mkVec(2'b00, 0, 0, 0, S_FETCH, 6'b0, 0, 0, 2'b00, 2'b00, 4'h0) & BASE_MASK});
      reset = 1'b0;
      $display("[TB] reset released, starting instruction stream");

      runInstr(32'hE2821005, 4'b0000, 0, 0);   // ADD R1,R2,#5
      runInstr(32'hE2933001, 4'b0010, 1, 0);   // ADDS R3,R3,#1 (C)
      runInstr(32'hE0500000, 4'b0110, 0, 0);   // SUBS R0,R0,R0 (Z,C)
      runInstr(32'h0A000003, 4'b0000, 0, 0);   // BEQ taken
      runInstr(32'h1A000003, 4'b0000, 0, 0);   // BNE not taken

      // Reset while the load sits in MEMREAD.
      planInstr(32'hE5912004, 4'b0000, 0, 3);
      applyStimulus(3);
      sb.delete();
      mem_ready = 1'b0;
      #2;
      checkOutput("memread_entered", {28'b0, state}, {28'b0, S_MEMREAD});
      reset = 1'b1;
      #1;
      checkOutput("reset_mid_memread", {6'b0, obsVec() & BASE_MASK},
                  {6'b0, mkVec(2'b01, 0, 0, 0, S_FETCH, 6'b0, 0, 0, 2'b00, 2'b00, 4'h0) & BASE_MASK});
      mem_ready = 1'b1;
      @(negedge clk);
      checkOutput("reset_hold_strobes", {6'b0, obsVec() & BASE_MASK},
                  {6'b0, mkVec(2'b01, 0, 0, 0, S_FETCH, 6'b0, 0, 0, 2'b00, 2'b00, 4'h0) & BASE_MASK});
      @(posedge clk);
      #1;
      reset  = 1'b0;
      m_nzcv = 4'h0;

      runInstr(32'h0A000003, 4'b0000, 0, 0);   // BEQ, flags cleared so not taken
      runInstr(32'hE5912004, 4'b0000, 0, 3);   // LDR R2,[R1,#4] with memory stall
      runInstr(32'hE7012003, 4'b0000, 2, 2);   // STR R2,[R1,-R3]
      runInstr(32'hEB000010, 4'b0000, 0, 0);   // BL
      runInstr(32'hEC000000, 4'b0000, 0, 0);   // illegal class
      runInstr(32'hE3500000, 4'b1000, 0, 0);   // CMP R0,#0 (N)
      runInstr(32'h4A000001, 4'b0000, 0, 0);   // BMI taken
      runInstr(32'hAA000001, 4'b0000, 0, 0);   // BGE not taken
      runInstr(32'hE591F000, 4'b0000, 0, 1);   // LDR PC
      runInstr(32'hE282F004, 4'b0000, 0, 0);   // ADD PC,R2,#4
      runInstr(32'hF2821005, 4'b0000, 0, 0);   // never-condition

      for (int i = 0; i < 30; i++) begin
         rins = $urandom;
         if ($urandom_range(0, 1) == 1) rins[31:28] = 4'hE;
         runInstr(rins, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences a multicycle variant of the ARM datapath: one shared instruction/data memory, an instruction register, and the ALU reused for PC increment.
- Decodes the DP, LDR/STR and B/BL classes, checks condition codes against an internal NZCV register, and steps each instruction through FETCH/DECODE/EXECUTE/WRITEBACK states.
- Drives every datapath mux select, write enable and ALU control.

Parameters:
- RESET_STATE, 4'd0, state encoding loaded on reset (FETCH).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears FSM and flags
- Instr  in  32  instruction register contents
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  load PC
- AdrSrc  out  1  0=PC, 1=ALU result to memory address
- IRWrite  out  1  load instruction register
- MemWrite  out  1  data store strobe
- RegWrite  out  1  register file write
- ResultSrc  out  2  00=ALUOut reg, 01=ReadData, 10=ALU direct
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=shifter operand, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  = Instr[27:26]
- RegSrc  out  2  {STR, branch}
- ALUControl  out  4  ARM opcode encoding (0100 ADD, 0010 SUB)
- BranchLink  out  1  write R14 with link value
- Rs_in_shifter  out  1  1 for memory instructions with register offset
- carry_flag  out  1  registered C
- illegal  out  1  one-cycle pulse on Instr[27:26]=11
- state  out  4  current state, for debug

Behaviour:
- Reset:
  - Asynchronous; state=FETCH, NZCV=0.
  - While reset is high, all strobes (PCWrite, IRWrite, MemWrite, RegWrite, BranchLink, illegal) are 0.
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10. While mem_ready=0, hold with strobes 0. When mem_ready=1, IRWrite=1, PCWrite=1, next=DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; registers read. If the condition fails, next=FETCH with no side effects. Otherwise Instr[27:26] selects next: 00 -> EXECUTER (Instr[25]=0) or EXECUTEI; 01 -> MEMADR; 10 -> BRANCH; 11 -> FETCH with illegal=1.
  - EXECUTER/EXECUTEI: ALUSrcA=0, ALUSrcB=00 (shifter handles register and immediate); ALUControl=Instr[24:21]; next=ALUWB.
  - ALUWB: ResultSrc=00. RegWrite=1 unless opcode is 10xx (TST/TEQ/CMP/CMN). If Instr[20]=1, NZCV<=ALUFlags captured in EXECUTE. If RegWrite and Rd=15, PCWrite=1. Next=FETCH.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD if U (Instr[23])=1 else SUB. Rs_in_shifter=Instr[25]. Next=MEMREAD if L (Instr[20])=1, else MEMWRITE.
  - MEMREAD: AdrSrc=1; hold until mem_ready; next=MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1; PCWrite=1 if Rd=15; next=FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1 and RegSrc[1]=1 every cycle until mem_ready; next=FETCH.
  - BRANCH: ALUSrcA=0 with RegSrc[0]=1 (reads PC+8), ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=1. If Instr[24]=1, BranchLink=1 and RegWrite=1. Next=FETCH.
- Condition check (Instr[31:28]):
  - Standard ARM EQ..LE evaluated on the registered NZCV.
  - 1110 (AL) always passes; 1111 never passes.
- Flag forwarding: flags written in ALUWB are visible to the next instruction's DECODE (at least 2 cycles later). No bypass is required.
- Reset mid-instruction: abort immediately, no partial writes after the reset edge.
- carry_flag equals registered C at all times.

Optional Feature:
- Macro: CTRL_MEMWAIT_EN.
- Defined: FETCH, MEMREAD and MEMWRITE stall on mem_ready as above.
- Undefined: mem_ready is ignored and treated as 1, so every memory state lasts exactly one cycle.

Test Plan:
- Reset high mid-MEMREAD, then released -> state=0 (FETCH), NZCV=0, no RegWrite pulse.
- ADD R1,R2,#5 (0xE2821005), mem_ready=1 -> FETCH,DECODE,EXECUTEI,ALUWB. RegWrite=1 only in ALUWB. Total 4 cycles.
- SUBS R0,R0,R0 then BEQ -> Z=1 latched in ALUWB; BEQ reaches BRANCH with PCWrite=1. BNE instead returns to FETCH from DECODE with no PCWrite.
- LDR with mem_ready low 3 cycles in MEMREAD (macro on) -> MEMREAD held 4 cycles, then one MEMWB with RegWrite=1. Macro off -> MEMREAD held 1 cycle.
- BL (0xEB000010) -> BRANCH asserts PCWrite=1, BranchLink=1, RegWrite=1 in the same cycle.
- Instr 0xEC000000 -> illegal pulses 1 cycle in DECODE; next state FETCH; no write strobes.
